// File: rtl/gpmc_pkg.sv
// Shared types and constants for the synchronous multiplexed GPMC master.
// Holds the FSM state enum, bus widths, default timing, and output-decode helper.
package gpmc_pkg;

    localparam int ADDR_W      = 11;
    localparam int DATA_W      = 16;
    localparam int RD_WAIT_DEF = 2;
    localparam int RECOV_DEF   = 1;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        WRDATA,
        RDWAIT,
        RECOVER
    } gpmc_state_e;

    typedef struct packed {
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [1:0]        be;
    } gpmc_req_t;

    // All strobes are active-low; ad_oe/dir follow the pad conventions.
    typedef struct packed {
        logic              cs;
        logic              adv;
        logic              oe;
        logic              we;
        logic              be0;
        logic              be1;
        logic              ad_oe;
        logic              dir;
        logic [DATA_W-1:0] ad_out;
    } gpmc_bus_t;

    localparam gpmc_bus_t BUS_IDLE = '{
        cs: 1'b1, adv: 1'b1, oe: 1'b1, we: 1'b1,
        be0: 1'b1, be1: 1'b1, ad_oe: 1'b0, dir: 1'b0,
        ad_out: '0
    };

    // Pad levels for the cycle spent in state st while serving request r.
    function automatic gpmc_bus_t bus_drive(input gpmc_state_e st, input gpmc_req_t r);
        gpmc_bus_t b;
        b = BUS_IDLE;
        case (st)
            ADDR: begin
                b.cs     = 1'b0;
                b.adv    = 1'b0;
                b.ad_out = DATA_W'(r.addr);
                b.ad_oe  = 1'b1;
                b.be0    = ~r.be[0];
                b.be1    = ~r.be[1];
            end
            WRDATA: begin
                b.cs     = 1'b0;
                b.we     = 1'b0;
                b.ad_out = r.wdata;
                b.ad_oe  = 1'b1;
                b.be0    = ~r.be[0];
                b.be1    = ~r.be[1];
            end
            RDWAIT: begin
                b.cs  = 1'b0;
                b.oe  = 1'b0;
                b.dir = 1'b1;
                b.be0 = ~r.be[0];
                b.be1 = ~r.be[1];
            end
            default: b = BUS_IDLE;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/gpmc_sync_master.sv
// Synchronous address/data-multiplexed GPMC bus master: one access at a time,
// single-word reads and byte-enabled writes, fully registered pad and response outputs.
module gpmc_sync_master
    import gpmc_pkg::*;
#(
    parameter int RD_WAIT = RD_WAIT_DEF,
    parameter int RECOV   = RECOV_DEF
) (
    input  logic              CLK,
    input  logic              RST,

    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [1:0]        req_be,

    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,

    output logic [DATA_W-1:0] GPMC_AD_OUT,
    output logic              GPMC_AD_OE,
    input  logic [DATA_W-1:0] GPMC_AD_IN,
    output logic              GPMC_CS,
    output logic              GPMC_ADV,
    output logic              GPMC_OE,
    output logic              GPMC_WE,
    output logic              GPMC_BE0,
    output logic              GPMC_BE1,
    output logic              GPMC_DIR
);

    localparam logic [3:0] RDW_LOAD = 4'(RD_WAIT - 1);
    localparam logic [3:0] REC_LOAD = (RECOV == 0) ? 4'd0 : 4'(RECOV - 1);

    gpmc_state_e state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    gpmc_req_t   req_q, req_nxt;
    gpmc_bus_t   bus_q, bus_nxt;
    logic        rsp_nxt;
    logic        capture;
    logic        finish;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        req_nxt   = req_q;
        rsp_nxt   = 1'b0;
        capture   = 1'b0;
        finish    = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    req_nxt   = '{wr: req_wr, addr: req_addr, wdata: req_wdata, be: req_be};
                    state_nxt = ADDR;
                end
            end
            ADDR: begin
                if (req_q.wr) begin
                    state_nxt = WRDATA;
                end else begin
                    state_nxt = RDWAIT;
                    cnt_nxt   = RDW_LOAD;
                end
            end
            WRDATA: begin
                rsp_nxt = 1'b1;
                finish  = 1'b1;
            end
            RDWAIT: begin
                if (cnt == 4'd0) begin
                    rsp_nxt = 1'b1;
                    capture = 1'b1;
                    finish  = 1'b1;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            RECOVER: begin
                if (cnt == 4'd0) state_nxt = IDLE;
                else             cnt_nxt   = cnt - 4'd1;
            end
            default: state_nxt = IDLE;
        endcase

        // With no recovery time the bus goes straight back to accepting requests.
        if (finish) begin
            if (RECOV == 0) begin
                state_nxt = IDLE;
                cnt_nxt   = 4'd0;
            end else begin
                state_nxt = RECOVER;
                cnt_nxt   = REC_LOAD;
            end
        end

        // Pads are decoded from the next state so they change on the same edge as the FSM.
        bus_nxt = bus_drive(state_nxt, req_nxt);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            req_q     <= '0;
            bus_q     <= BUS_IDLE;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            req_q     <= req_nxt;
            bus_q     <= bus_nxt;
            rsp_valid <= rsp_nxt;
            if (capture) rsp_rdata <= GPMC_AD_IN;
        end
    end

    assign req_ready   = (state == IDLE);
    assign GPMC_AD_OUT = bus_q.ad_out;
    assign GPMC_AD_OE  = bus_q.ad_oe;
    assign GPMC_CS     = bus_q.cs;
    assign GPMC_ADV    = bus_q.adv;
    assign GPMC_OE     = bus_q.oe;
    assign GPMC_WE     = bus_q.we;
    assign GPMC_BE0    = bus_q.be0;
    assign GPMC_BE1    = bus_q.be1;
    assign GPMC_DIR    = bus_q.dir;

endmodule

// File: tb/tb_gpmc_sync_master.sv
// Bench for gpmc_sync_master: SRAM-style responder plus 2K x 16 memory, queue scoreboard
// for completions, and directed pad-level checks; a second instance covers RD_WAIT=1/RECOV=0.
module tb_gpmc_sync_master;
    import gpmc_pkg::*;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;
    logic RST;

    logic        req_valid, req_ready, req_wr;
    logic [10:0] req_addr;
    logic [15:0] req_wdata;
    logic [1:0]  req_be;
    logic        rsp_valid;
    logic [15:0] rsp_rdata, ad_out, ad_in;
    logic        ad_oe, cs, adv, oe, we, be0, be1, dir;

    logic        req_valid2, req_ready2, req_wr2;
    logic [10:0] req_addr2;
    logic [15:0] req_wdata2;
    logic [1:0]  req_be2;
    logic        rsp_valid2;
    logic [15:0] rsp_rdata2, ad_out2, ad_in2;
    logic        ad_oe2, cs2, adv2, oe2, we2, be0_2, be1_2, dir2;

    gpmc_sync_master dut (
        .CLK(CLK), .RST(RST),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .GPMC_AD_OUT(ad_out), .GPMC_AD_OE(ad_oe), .GPMC_AD_IN(ad_in),
        .GPMC_CS(cs), .GPMC_ADV(adv), .GPMC_OE(oe), .GPMC_WE(we),
        .GPMC_BE0(be0), .GPMC_BE1(be1), .GPMC_DIR(dir)
    );

    gpmc_sync_master #(.RD_WAIT(1), .RECOV(0)) dut2 (
        .CLK(CLK), .RST(RST),
        .req_valid(req_valid2), .req_ready(req_ready2), .req_wr(req_wr2),
        .req_addr(req_addr2), .req_wdata(req_wdata2), .req_be(req_be2),
        .rsp_valid(rsp_valid2), .rsp_rdata(rsp_rdata2),
        .GPMC_AD_OUT(ad_out2), .GPMC_AD_OE(ad_oe2), .GPMC_AD_IN(ad_in2),
        .GPMC_CS(cs2), .GPMC_ADV(adv2), .GPMC_OE(oe2), .GPMC_WE(we2),
        .GPMC_BE0(be0_2), .GPMC_BE1(be1_2), .GPMC_DIR(dir2)
    );

    // SRAM responder: latch address on ADV, write enabled bytes on WE, drive data on OE.
    logic [15:0] mem [2048];
    logic [10:0] a_lat, a_lat2;
    initial for (int i = 0; i < 2048; i++) mem[i] <= 16'(i) ^ 16'h5A5A;

    always @(posedge CLK) begin
        if (!cs && !adv) a_lat <= ad_out[10:0];
        if (!cs && !we) begin
            if (!be0) mem[a_lat][7:0]  <= ad_out[7:0];
            if (!be1) mem[a_lat][15:8] <= ad_out[15:8];
        end
        if (!cs2 && !adv2) a_lat2 <= ad_out2[10:0];
    end
    assign ad_in  = (!cs && !oe)   ? mem[a_lat] : 16'hDEAD;
    assign ad_in2 = (!cs2 && !oe2) ? (16'(a_lat2) ^ 16'h5A5A) : 16'hDEAD;

    int checks = 0, errors = 0, cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        wr;
        logic [15:0] rdata;
        int          due;
    } exp_t;
    exp_t sbq[$];

    always @(negedge CLK) begin
        if (rsp_valid === 1'b1) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rsp_unexpected: got rsp_valid=1 expected none (cyc=%0d)", cyc);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("rsp_cycle", cyc, e.due);
                if (!e.wr) chk("rsp_rdata", rsp_rdata, e.rdata);
            end
        end
    end

    // Present a request and wait for acceptance; returns just after the accepting edge
    // with req_valid still high so callers can chain back-to-back requests.
    task automatic issue(input logic wr, input logic [10:0] a, input logic [15:0] d,
                         input logic [1:0] be, input logic [15:0] exp_rd, input bit push,
                         output int acc);
        @(negedge CLK);
        req_valid = 1'b1;
        req_wr    = wr;
        req_addr  = a;
        req_wdata = d;
        req_be    = be;
        for (int t = 0; t < 40 && req_ready !== 1'b1; t++) @(negedge CLK);
        acc = cyc;
        if (req_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got req_ready=%b expected 1", req_ready);
        end else if (push) begin
            sbq.push_back('{wr, exp_rd, cyc + 1 + (wr ? 2 : 3)});
        end
        @(posedge CLK);
        #1;
    endtask

    initial begin
        int a0, a1;
        RST = 1'b1;
        req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
        req_valid2 = 1'b0; req_wr2 = 1'b0; req_addr2 = '0; req_wdata2 = '0; req_be2 = '0;
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b0;
        chk("rst_strobes", {cs, adv, oe, we, be0, be1, ad_oe, dir}, 8'b11111100);
        chk("rst_ad_out", ad_out, 16'h0000);
        chk("rst_rsp", {rsp_valid, rsp_rdata}, 17'h0);
        chk("rst_ready", req_ready, 1'b1);

        // Write 0xBEEF to 0x123, both bytes.
        issue(1'b1, 11'h123, 16'hBEEF, 2'b11, 16'h0, 1'b1, a0);
        req_valid = 1'b0;
        chk("wr_addr_ph", {cs, adv, we, oe, ad_oe, dir}, 6'b001110);
        chk("wr_addr_ad", ad_out, 16'h0123);
        chk("wr_busy", req_ready, 1'b0);
        @(posedge CLK); #1;
        chk("wr_data_ph", {cs, adv, we, be0, be1, ad_oe}, 6'b010001);
        chk("wr_data_ad", ad_out, 16'hBEEF);
        @(posedge CLK); #1;
        chk("wr_recover", {cs, adv, oe, we, be0, be1, ad_oe}, 7'b1111110);

        // Read it back: two wait cycles with OE low and the bus turned around.
        issue(1'b0, 11'h123, 16'h0, 2'b11, 16'hBEEF, 1'b1, a0);
        req_valid = 1'b0;
        @(posedge CLK); #1;
        chk("rd_wait1", {cs, adv, oe, we, ad_oe, dir}, 6'b010101);
        @(posedge CLK); #1;
        chk("rd_wait2", {cs, adv, oe, we, ad_oe, dir}, 6'b010101);
        @(posedge CLK); #1;
        chk("rd_done", {cs, oe}, 2'b11);

        // No byte enabled: full cycle, memory untouched.
        issue(1'b1, 11'h010, 16'h1111, 2'b00, 16'h0, 1'b1, a0);
        req_valid = 1'b0;
        @(posedge CLK); #1;
        chk("be00_we", {we, be0, be1}, 3'b011);
        issue(1'b0, 11'h010, 16'h0, 2'b11, 16'h5A4A, 1'b1, a0);
        // Low byte only.
        issue(1'b1, 11'h020, 16'hABCD, 2'b01, 16'h0, 1'b1, a0);
        issue(1'b0, 11'h020, 16'h0, 2'b11, 16'h5ACD, 1'b1, a0);
        req_valid = 1'b0;

        // Back-to-back writes then reads with req_valid held high.
        issue(1'b1, 11'h030, 16'h1234, 2'b11, 16'h0, 1'b1, a0);
        issue(1'b1, 11'h031, 16'h5678, 2'b11, 16'h0, 1'b1, a1);
        chk("b2b_wr_spacing", a1 - a0, 4);
        issue(1'b0, 11'h030, 16'h0, 2'b11, 16'h1234, 1'b1, a0);
        issue(1'b0, 11'h031, 16'h0, 2'b11, 16'h5678, 1'b1, a1);
        req_valid = 1'b0;
        chk("b2b_rd_spacing", a1 - a0, 5);

        // Reset in the second wait cycle aborts the read silently.
        issue(1'b0, 11'h123, 16'h0, 2'b11, 16'h0, 1'b0, a0);
        req_valid = 1'b0;
        @(posedge CLK);
        @(posedge CLK); #1;
        chk("abort_in_wait", oe, 1'b0);
        RST = 1'b1;
        @(posedge CLK); #1;
        chk("abort_strobes", {cs, adv, oe, we, be0, be1, ad_oe, dir}, 8'b11111100);
        chk("abort_no_rsp", rsp_valid, 1'b0);
        RST = 1'b0;
        @(posedge CLK); #1;
        chk("abort_ready", req_ready, 1'b1);
        chk("abort_rdata_clr", rsp_rdata, 16'h0);

        // Minimum timing instance: top address, low byte, single wait, no recovery.
        @(negedge CLK);
        req_valid2 = 1'b1; req_wr2 = 1'b0; req_addr2 = 11'h7FF; req_be2 = 2'b01;
        chk("d2_ready", req_ready2, 1'b1);
        @(posedge CLK); #1;
        req_valid2 = 1'b0;
        chk("d2_addr_ph", {cs2, adv2, be0_2, be1_2}, 4'b0001);
        chk("d2_addr_ad", ad_out2, 16'h07FF);
        @(posedge CLK); #1;
        chk("d2_wait", {oe2, dir2}, 2'b01);
        @(posedge CLK); #1;
        chk("d2_rsp", {rsp_valid2, rsp_rdata2}, {1'b1, 16'h5DA5});
        chk("d2_idle", {req_ready2, oe2, cs2}, 3'b111);

        repeat (10) @(posedge CLK);
        #1;
        chk("sb_drained", sbq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
